// File: rtl/rect_motion_ctrl.sv
// Frame-synchronous position/press-animation sequencer for one drum pad rectangle.
// Position updates and hits are buffered mid-frame and applied only on the vsync falling edge.
module rect_motion_ctrl #(
  parameter int H_LIMIT     = 1024,
  parameter int V_LIMIT     = 768,
  parameter int RECT_W      = 64,
  parameter int RECT_H      = 64,
  parameter int DIP         = 8,
  parameter int HOLD_FRAMES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [10:0] cfg_x,
  input  logic [9:0]  cfg_y,
  input  logic        hit,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        active,
  output logic [7:0]  hit_count
);

  // cfg handshake: a transfer happens on any cycle with cfg_valid & cfg_ready;
  // cfg_valid may be held, cfg_ready stays low while a position awaits the next tick.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_RISE = 2'd2
  } state_t;

  localparam logic [10:0] X_MAX  = 11'(H_LIMIT - RECT_W);
  localparam logic [9:0]  Y_MAX  = 10'(V_LIMIT - RECT_H - DIP);
  localparam logic [3:0]  DIP_V  = 4'(DIP);
  localparam logic [3:0]  HOLD_V = 4'(HOLD_FRAMES);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_vsync_d;
  logic        r_cfg_pend;
  logic        r_cfg_ready;
  logic [10:0] r_cfg_x;
  logic [9:0]  r_cfg_y;
  logic        r_hit_pend;
  logic [10:0] r_base_x;
  logic [9:0]  r_base_y;
  logic [3:0]  r_offset;
  logic [3:0]  r_hold;
  logic [7:0]  r_count;
  logic [10:0] r_x;
  logic [9:0]  r_y;

  logic        w_tick;
  logic        w_xfer;
  logic [10:0] w_clamp_x;
  logic [9:0]  w_clamp_y;
  logic [10:0] w_base_x_nxt;
  logic [9:0]  w_base_y_nxt;
  logic [3:0]  w_offset_nxt;
  logic [3:0]  w_hold_nxt;
  logic [7:0]  w_count_nxt;
  logic [9:0]  w_y_nxt;

  assign w_tick    = r_vsync_d & ~vsync;
  assign w_xfer    = cfg_valid & r_cfg_ready;
  assign w_clamp_x = (r_cfg_x > X_MAX) ? X_MAX : r_cfg_x;
  assign w_clamp_y = (r_cfg_y > Y_MAX) ? Y_MAX : r_cfg_y;
  assign w_y_nxt   = w_base_y_nxt + {6'd0, w_offset_nxt};

  // Next-frame values; everything holds except on the tick cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_offset_nxt = r_offset;
    w_hold_nxt   = r_hold;
    w_count_nxt  = r_count;
    w_base_x_nxt = r_base_x;
    w_base_y_nxt = r_base_y;
    if (w_tick) begin
      if (r_cfg_pend) begin
        w_base_x_nxt = w_clamp_x;
        w_base_y_nxt = w_clamp_y;
      end
      if (r_hit_pend) begin
        w_offset_nxt = DIP_V;
        w_hold_nxt   = HOLD_V;
        w_count_nxt  = (r_count == 8'hFF) ? r_count : r_count + 8'd1;
        w_state_nxt  = S_HOLD;
      end else begin
        case (r_state)
          S_HOLD: begin
            w_hold_nxt = r_hold - 4'd1;
            if (r_hold == 4'd1) w_state_nxt = S_RISE;
          end
          S_RISE: begin
            w_offset_nxt = r_offset - 4'd1;
            if (r_offset == 4'd1) w_state_nxt = S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vsync_d   <= 1'b1;
      r_cfg_pend  <= 1'b0;
      r_cfg_ready <= 1'b1;
      r_cfg_x     <= '0;
      r_cfg_y     <= '0;
      r_hit_pend  <= 1'b0;
      r_base_x    <= '0;
      r_base_y    <= '0;
      r_offset    <= '0;
      r_hold      <= '0;
      r_count     <= '0;
      r_x         <= '0;
      r_y         <= '0;
    end else begin
      r_vsync_d <= vsync;
      r_offset  <= w_offset_nxt;
      r_hold    <= w_hold_nxt;
      r_count   <= w_count_nxt;
      r_base_x  <= w_base_x_nxt;
      r_base_y  <= w_base_y_nxt;
      // A hit on the tick cycle itself belongs to the next frame.
      r_hit_pend <= w_tick ? hit : (r_hit_pend | hit);
      if (w_xfer) begin
        r_cfg_x     <= cfg_x;
        r_cfg_y     <= cfg_y;
        r_cfg_pend  <= 1'b1;
        r_cfg_ready <= 1'b0;
      end else if (w_tick && r_cfg_pend) begin
        r_cfg_pend  <= 1'b0;
        r_cfg_ready <= 1'b1;
      end
      if (w_tick) begin
        r_x <= w_base_x_nxt;
        r_y <= w_y_nxt;
      end
    end
  end

  assign cfg_ready = r_cfg_ready;
  assign x         = r_x;
  assign y         = r_y;
  assign active    = (r_state != S_IDLE);
  assign hit_count = r_count;

endmodule

// File: tb/tb_rect_motion_ctrl.sv
// Directed bench for rect_motion_ctrl: per-frame vector table plus hand sequences
// for tick-cycle inputs, multi-hit frames and mid-animation reset.
module tb_rect_motion_ctrl;

  logic        clk;
  logic        reset;
  logic        vsync;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [10:0] cfg_x;
  logic [9:0]  cfg_y;
  logic        hit;
  logic [10:0] x;
  logic [9:0]  y;
  logic        active;
  logic [7:0]  hit_count;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        hit;
    logic        cv;
    logic [10:0] cx;
    logic [9:0]  cy;
    logic [10:0] ex;
    logic [9:0]  ey;
    logic        ea;
    logic [7:0]  ec;
  } vec_t;

  vec_t vq[$];
  logic [10:0] prev_x;
  logic [9:0]  prev_y;

  rect_motion_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .vsync     (vsync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_x     (cfg_x),
    .cfg_y     (cfg_y),
    .hit       (hit),
    .x         (x),
    .y         (y),
    .active    (active),
    .hit_count (hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic h, input logic cv, input int cx, input int cy,
                         input int ex, input int ey, input logic ea, input int ec);
    vec_t v;
    v.hit = h; v.cv = cv; v.cx = 11'(cx); v.cy = 10'(cy);
    v.ex = 11'(ex); v.ey = 10'(ey); v.ea = ea; v.ec = 8'(ec);
    vq.push_back(v);
  endtask

  // Tick cycle: vsync falls with the given inputs applied for that one cycle.
  task automatic tick_cycle(input logic h, input logic cv, input logic [10:0] cx, input logic [9:0] cy);
    vsync = 1'b0; hit = h; cfg_valid = cv; cfg_x = cx; cfg_y = cy;
    @(negedge clk);
    hit = 1'b0; cfg_valid = 1'b0;
  endtask

  task automatic end_sync();
    @(negedge clk);
    vsync = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_out(input string tag, input logic [10:0] ex, input logic [9:0] ey,
                           input logic ea, input logic [7:0] ec, input logic er);
    check({tag, "_x"}, 32'(x), 32'(ex));
    check({tag, "_y"}, 32'(y), 32'(ey));
    check({tag, "_active"}, 32'(active), 32'(ea));
    check({tag, "_count"}, 32'(hit_count), 32'(ec));
    check({tag, "_ready"}, 32'(cfg_ready), 32'(er));
  endtask

  task automatic apply_frame(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    hit = v.hit; cfg_valid = v.cv; cfg_x = v.cx; cfg_y = v.cy;
    @(negedge clk);
    hit = 1'b0; cfg_valid = 1'b0;
    if (v.cv) check({tag, "_pend_ready"}, 32'(cfg_ready), 32'd0);
    repeat (2) @(negedge clk);
    check({tag, "_pre_x"}, 32'(x), 32'(prev_x));
    check({tag, "_pre_y"}, 32'(y), 32'(prev_y));
    tick_cycle(1'b0, 1'b0, 11'd0, 10'd0);
    check_out(tag, v.ex, v.ey, v.ea, v.ec, 1'b1);
    prev_x = v.ex;
    prev_y = v.ey;
    end_sync();
  endtask

  initial begin
    reset = 1'b1; vsync = 1'b1; cfg_valid = 1'b0; cfg_x = '0; cfg_y = '0; hit = 1'b0;
    prev_x = '0; prev_y = '0;

    for (int i = 0; i < 3; i++) add_vec(0, 0, 0, 0, 0, 0, 0, 0);
    add_vec(0, 1, 100, 200, 100, 200, 0, 0);
    add_vec(0, 1, 2000, 1000, 960, 696, 0, 0);
    add_vec(0, 1, 961, 697, 960, 696, 0, 0);
    add_vec(0, 1, 960, 0, 960, 0, 0, 0);
    add_vec(0, 1, 100, 200, 100, 200, 0, 0);
    add_vec(1, 0, 0, 0, 100, 208, 1, 1);
    for (int i = 0; i < 4; i++) add_vec(0, 0, 0, 0, 100, 208, 1, 1);
    for (int i = 7; i >= 1; i--) add_vec(0, 0, 0, 0, 100, 200 + i, 1, 1);
    add_vec(0, 0, 0, 0, 100, 200, 0, 1);
    add_vec(1, 0, 0, 0, 100, 208, 1, 2);
    for (int i = 0; i < 4; i++) add_vec(0, 0, 0, 0, 100, 208, 1, 2);
    for (int i = 7; i >= 4; i--) add_vec(0, 0, 0, 0, 100, 200 + i, 1, 2);
    add_vec(1, 0, 0, 0, 100, 208, 1, 3);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_out("reset", 11'd0, 10'd0, 1'b0, 8'd0, 1'b1);

    foreach (vq[i]) apply_frame(i, vq[i]);

    // Hit and cfg both on the tick cycle: neither applies until the following tick.
    tick_cycle(1'b1, 1'b1, 11'd300, 10'd100);
    check_out("tickin_a", 11'd100, 10'd208, 1'b1, 8'd3, 1'b0);
    end_sync();
    tick_cycle(1'b0, 1'b0, 11'd0, 10'd0);
    check_out("tickin_b", 11'd300, 10'd108, 1'b1, 8'd4, 1'b1);
    end_sync();

    // Three separate hit pulses in one frame count once.
    for (int i = 0; i < 3; i++) begin
      hit = 1'b1;
      @(negedge clk);
      hit = 1'b0;
      @(negedge clk);
    end
    tick_cycle(1'b0, 1'b0, 11'd0, 10'd0);
    check_out("multihit", 11'd300, 10'd108, 1'b1, 8'd5, 1'b1);
    end_sync();
    tick_cycle(1'b0, 1'b0, 11'd0, 10'd0);
    check_out("hold_next", 11'd300, 10'd108, 1'b1, 8'd5, 1'b1);
    end_sync();

    // Reset mid-HOLD with a position and a hit still pending.
    cfg_valid = 1'b1; cfg_x = 11'd500; cfg_y = 10'd50;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("rst_pre_ready", 32'(cfg_ready), 32'd0);
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_out("midreset", 11'd0, 10'd0, 1'b0, 8'd0, 1'b1);
    repeat (2) @(negedge clk);
    tick_cycle(1'b0, 1'b0, 11'd0, 10'd0);
    check_out("post_reset_tick", 11'd0, 10'd0, 1'b0, 8'd0, 1'b1);
    end_sync();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
